stopwatch_lap_core: RTL
=======================

Name: stopwatch_lap_core

Overview:
- Parametrised successor to the single-channel stopwatch logic. Counts up or down in hh:mm:ss.xx on edges of a slow tick clock.
- Adds explicit preset load, a done pulse and a lap-capture FIFO with first-word-fall-through (FWFT) read. Range limits are generalised.
- Sits between the button debouncers / tick divider and the display mux. The display mux reads either the live time or the FIFO head.

Parameters:
- TICKS_PER_SEC, 100, sub-second ticks per second. xx range is 0..TICKS_PER_SEC-1. Must be 2..256.
- HOUR_MAX, 99, maximum hour value. Must be ≤255.
- LAP_DEPTH, 8, lap FIFO entries. Power of two, ≥2.
- LAP_AW, 3, log2(LAP_DEPTH).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- tick_in  in  1  slow timing clock, level; rising edge detected internally against clk
- start  in  1  one-cycle pulse: run
- stop  in  1  one-cycle pulse: pause
- clear  in  1  one-cycle pulse: zero time, empty FIFO, go IDLE
- dir_down  in  1  1 = countdown, 0 = count up
- preset_load  in  1  one-cycle pulse: load preset fields into time
- preset_hh  in  8  preset hours
- preset_mm  in  8  preset minutes
- preset_ss  in  8  preset seconds
- lap  in  1  one-cycle pulse: capture current time into FIFO
- lap_rd  in  1  one-cycle pulse: pop FIFO head
- xx, ss, mm, hh  out  8 each  live time, binary
- running  out  1  state == RUN
- done  out  1  one-cycle pulse, countdown reached zero
- lap_time  out  32  FIFO head {hh,mm,ss,xx}; 0 when empty
- lap_count  out  LAP_AW+1  FIFO occupancy
- lap_empty, lap_full  out  1 each  FIFO flags
- lap_overflow  out  1  sticky: a lap was dropped because the FIFO was full

Behaviour:
- Reset (rst=1 at posedge clk):
  - state=IDLE; all time fields 0; done=0; running=0.
  - FIFO empty: lap_count=0, lap_empty=1, lap_full=0, lap_time=0; lap_overflow=0.
  - Tick edge-detect register = 0.
- States: IDLE, RUN, PAUSE, DONE.
  - IDLE/PAUSE --start--> RUN. Exception: start is ignored when dir_down=1 and time is all zero.
  - RUN --stop--> PAUSE.
  - RUN --countdown hits zero--> DONE.
  - DONE --start--> ignored.
  - Any state --clear--> IDLE.
- Priority within one cycle: rst > clear > preset_load > start > stop. Simultaneous start and stop while not RUN: start wins; stop is ignored that cycle.
- preset_load is honoured only in IDLE, PAUSE or DONE.
  - Loads hh=min(preset_hh,HOUR_MAX), mm=min(preset_mm,59), ss=min(preset_ss,59), xx=0.
  - From DONE, the state goes to PAUSE.
  - preset_load is ignored in RUN.
- Counting: one step per tick rising edge while RUN only, no latency beyond one clk. Ticks in other states are discarded; there is no catch-up.
- Up-count:
  - xx wraps TICKS_PER_SEC-1 → 0 and carries into ss.
  - ss wraps 59 → 0 and carries into mm; mm wraps 59 → 0 and carries into hh.
  - HOUR_MAX:59:59.(T-1) → 00:00:00.00, and counting continues.
- Down-count:
  - Borrow chain mirrors the up-count.
  - The tick that makes time 0 sets state=DONE. done=1 on the following clk for exactly one cycle.
  - Time never goes below zero.
- Direction change while RUN takes effect on the next tick. No other effect.
- Lap FIFO:
  - lap in RUN or PAUSE writes the current registered time (the value before any same-cycle tick update).
  - lap in IDLE or DONE is ignored.
  - Write when full: entry dropped, lap_overflow set. lap_overflow clears only on clear or rst.
  - lap_rd when empty is ignored.
  - Simultaneous write and read when full: both occur, count unchanged, no overflow.
  - Simultaneous write and read when empty: write only.
  - lap_time is registered and shows the head one clk after the write into an empty FIFO, or one clk after the pop.
- clear mid-run: next cycle time=0, state=IDLE, FIFO empty, lap_overflow=0, done=0.

Optional Feature:
- Macro: STOPWATCH_AUTORELOAD_EN.
- Defined:
  - The last accepted preset is held in a reload register (reset value 0).
  - When a countdown reaches zero, done pulses as normal, time reloads from the preset on the same clk, and the state stays RUN.
  - If the reload value is zero, the block behaves as if the macro were not defined.
- Undefined: no reload register; reaching zero enters DONE.

Test Plan:
- Reset, start, 150 tick edges with dir_down=0 → ss=1, xx=50, running=1. stop, 10 ticks → time unchanged, state PAUSE.
- TICKS_PER_SEC=100, HOUR_MAX=2: preset 02:59:59 (xx forced 0), set xx to 99 via 99 up-ticks, start, 1 tick → 00:00:00.00; counting continues.
- dir_down=1, preset 00:00:01, start, 100 ticks → time 0, state DONE, single-cycle done. Further start → ignored.
- 9 laps in RUN with LAP_DEPTH=8 → lap_full=1, lap_overflow=1, lap_count=8. 8 lap_rd → entries in capture order, then lap_empty=1, lap_time=0.
- Same cycle: start+stop in IDLE → RUN. lap+lap_rd with FIFO full → count stays 8, no overflow. preset_load in RUN → ignored.
- With STOPWATCH_AUTORELOAD_EN: preset 00:00:01, countdown, 200 ticks → two done pulses, running stays 1, time 00:00:01.00 after each reload.

Source files
------------

// File: rtl/stopwatch_lap_core_if.sv
// ============================================================================
//  Module   : stopwatch_lap_core_if
//  Purpose  : Control, live-time and lap-FIFO signals of stopwatch_lap_core.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stopwatch_lap_core_if #(
    parameter int LAP_AW = 3
);
    logic              tick_in;
    logic              start;
    logic              stop;
    logic              clear;
    logic              dir_down;
    logic              preset_load;
    logic [7:0]        preset_hh;
    logic [7:0]        preset_mm;
    logic [7:0]        preset_ss;
    logic              lap;
    logic              lap_rd;
    logic [7:0]        xx;
    logic [7:0]        ss;
    logic [7:0]        mm;
    logic [7:0]        hh;
    logic              running;
    logic              done;
    logic [31:0]       lap_time;
    logic [LAP_AW:0]   lap_count;
    logic              lap_empty;
    logic              lap_full;
    logic              lap_overflow;

    modport master (
        output tick_in, start, stop, clear, dir_down, preset_load,
               preset_hh, preset_mm, preset_ss, lap, lap_rd,
        input  xx, ss, mm, hh, running, done, lap_time, lap_count,
               lap_empty, lap_full, lap_overflow
    );

    modport slave (
        input  tick_in, start, stop, clear, dir_down, preset_load,
               preset_hh, preset_mm, preset_ss, lap, lap_rd,
        output xx, ss, mm, hh, running, done, lap_time, lap_count,
               lap_empty, lap_full, lap_overflow
    );
endinterface

`default_nettype wire

// File: rtl/stopwatch_lap_core.sv
// ============================================================================
//  Module   : stopwatch_lap_core
//  Purpose  : Up/down hh:mm:ss.xx stopwatch with preset, done pulse and FWFT
//             lap FIFO. Optional macro STOPWATCH_AUTORELOAD_EN reloads preset.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_lap_core #(
    parameter int TICKS_PER_SEC = 100,
    parameter int HOUR_MAX      = 99,
    parameter int LAP_DEPTH     = 8,
    parameter int LAP_AW        = 3
) (
    input wire                  clk,
    input wire                  rst,
    stopwatch_lap_core_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0]        c_xx_max  = 8'(TICKS_PER_SEC - 1);
    localparam logic [7:0]        c_hh_max  = 8'(HOUR_MAX);
    localparam logic [7:0]        c_sec_max = 8'd59;
    localparam logic [LAP_AW:0]   c_depth   = (LAP_AW + 1)'(LAP_DEPTH);
    localparam logic [LAP_AW-1:0] c_ptr_one = 1;
    localparam logic [LAP_AW:0]   c_cnt_one = 1;

    state_t     r_state, w_state_nxt;
    logic       r_tick_q, r_done, w_done_nxt;
    logic [7:0] r_hh, r_mm, r_ss, r_xx;
    logic [7:0] w_hh_nxt, w_mm_nxt, w_ss_nxt, w_xx_nxt;
    logic [7:0] w_up_hh, w_up_mm, w_up_ss, w_up_xx;
    logic [7:0] w_dn_hh, w_dn_mm, w_dn_ss, w_dn_xx;
    logic [7:0] w_ps_hh, w_ps_mm, w_ps_ss;
    logic [7:0] w_rl_hh, w_rl_mm, w_rl_ss;
    logic       w_zero, w_hits_zero, w_step, w_preset_ok, w_reload_ok;

    assign w_zero      = ({r_hh, r_mm, r_ss, r_xx} == 32'd0);
    assign w_hits_zero = (r_hh == 8'd0) && (r_mm == 8'd0) && (r_ss == 8'd0) && (r_xx <= 8'd1);
    assign w_step      = (r_state == S_RUN) && bus.tick_in && !r_tick_q;
    assign w_preset_ok = bus.preset_load && !bus.clear && (r_state != S_RUN);
    assign w_ps_hh     = (bus.preset_hh > c_hh_max)  ? c_hh_max  : bus.preset_hh;
    assign w_ps_mm     = (bus.preset_mm > c_sec_max) ? c_sec_max : bus.preset_mm;
    assign w_ps_ss     = (bus.preset_ss > c_sec_max) ? c_sec_max : bus.preset_ss;

`ifdef STOPWATCH_AUTORELOAD_EN
    logic [7:0] r_rl_hh, r_rl_mm, r_rl_ss;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rl_hh <= 8'd0;
            r_rl_mm <= 8'd0;
            r_rl_ss <= 8'd0;
        end else if (w_preset_ok) begin
            r_rl_hh <= w_ps_hh;
            r_rl_mm <= w_ps_mm;
            r_rl_ss <= w_ps_ss;
        end
    end

    assign w_rl_hh = r_rl_hh;
    assign w_rl_mm = r_rl_mm;
    assign w_rl_ss = r_rl_ss;
`else
    assign w_rl_hh = 8'd0;
    assign w_rl_mm = 8'd0;
    assign w_rl_ss = 8'd0;
`endif
    // A zero reload value falls back to the plain stop-at-zero behaviour.
    assign w_reload_ok = ({w_rl_hh, w_rl_mm, w_rl_ss} != 24'd0);

    always_comb begin
        {w_up_hh, w_up_mm, w_up_ss, w_up_xx} = {r_hh, r_mm, r_ss, r_xx};
        if (r_xx != c_xx_max) begin
            w_up_xx = r_xx + 8'd1;
        end else begin
            w_up_xx = 8'd0;
            if (r_ss != c_sec_max) begin
                w_up_ss = r_ss + 8'd1;
            end else begin
                w_up_ss = 8'd0;
                if (r_mm != c_sec_max) begin
                    w_up_mm = r_mm + 8'd1;
                end else begin
                    w_up_mm = 8'd0;
                    w_up_hh = (r_hh >= c_hh_max) ? 8'd0 : r_hh + 8'd1;
                end
            end
        end
    end

    always_comb begin
        {w_dn_hh, w_dn_mm, w_dn_ss, w_dn_xx} = {r_hh, r_mm, r_ss, r_xx};
        if (r_xx != 8'd0) begin
            w_dn_xx = r_xx - 8'd1;
        end else begin
            w_dn_xx = c_xx_max;
            if (r_ss != 8'd0) begin
                w_dn_ss = r_ss - 8'd1;
            end else begin
                w_dn_ss = c_sec_max;
                if (r_mm != 8'd0) begin
                    w_dn_mm = r_mm - 8'd1;
                end else begin
                    w_dn_mm = c_sec_max;
                    w_dn_hh = r_hh - 8'd1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        {w_hh_nxt, w_mm_nxt, w_ss_nxt, w_xx_nxt} = {r_hh, r_mm, r_ss, r_xx};
        w_done_nxt = 1'b0;
        if (bus.clear) begin
            w_state_nxt = S_IDLE;
            {w_hh_nxt, w_mm_nxt, w_ss_nxt, w_xx_nxt} = 32'd0;
        end else begin
            if (w_preset_ok) begin
                {w_hh_nxt, w_mm_nxt, w_ss_nxt, w_xx_nxt} = {w_ps_hh, w_ps_mm, w_ps_ss, 8'd0};
                if (r_state == S_DONE) w_state_nxt = S_PAUSE;
            end else if (bus.start && (r_state == S_IDLE || r_state == S_PAUSE)
                         && !(bus.dir_down && w_zero)) begin
                w_state_nxt = S_RUN;
            end else if (bus.stop && r_state == S_RUN) begin
                w_state_nxt = S_PAUSE;
            end
            // Reaching zero overrides a same-cycle stop.
            if (w_step) begin
                if (!bus.dir_down) begin
                    {w_hh_nxt, w_mm_nxt, w_ss_nxt, w_xx_nxt} = {w_up_hh, w_up_mm, w_up_ss, w_up_xx};
                end else if (w_hits_zero) begin
                    w_done_nxt = 1'b1;
                    if (w_reload_ok) begin
                        {w_hh_nxt, w_mm_nxt, w_ss_nxt, w_xx_nxt} = {w_rl_hh, w_rl_mm, w_rl_ss, 8'd0};
                    end else begin
                        {w_hh_nxt, w_mm_nxt, w_ss_nxt, w_xx_nxt} = 32'd0;
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    {w_hh_nxt, w_mm_nxt, w_ss_nxt, w_xx_nxt} = {w_dn_hh, w_dn_mm, w_dn_ss, w_dn_xx};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_tick_q <= 1'b0;
            r_done   <= 1'b0;
            {r_hh, r_mm, r_ss, r_xx} <= 32'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_tick_q <= bus.tick_in;
            r_done   <= w_done_nxt;
            {r_hh, r_mm, r_ss, r_xx} <= {w_hh_nxt, w_mm_nxt, w_ss_nxt, w_xx_nxt};
        end
    end

    logic [31:0]       r_mem [LAP_DEPTH];
    logic [LAP_AW-1:0] r_wr_ptr, r_rd_ptr, w_rd_ptr_nxt;
    logic [LAP_AW:0]   r_count, w_count_nxt;
    logic [31:0]       r_lap_time, w_head_nxt, w_wdata;
    logic              r_overflow, w_lap_ok, w_full, w_empty, w_wr, w_rd;

    assign w_wdata      = {r_hh, r_mm, r_ss, r_xx};
    assign w_lap_ok     = bus.lap && (r_state == S_RUN || r_state == S_PAUSE);
    assign w_full       = (r_count == c_depth);
    assign w_empty      = (r_count == '0);
    assign w_rd         = bus.lap_rd && !w_empty;
    assign w_wr         = w_lap_ok && (!w_full || w_rd);
    assign w_rd_ptr_nxt = w_rd ? r_rd_ptr + c_ptr_one : r_rd_ptr;

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr && !w_rd)      w_count_nxt = r_count + c_cnt_one;
        else if (!w_wr && w_rd) w_count_nxt = r_count - c_cnt_one;
        // Bypass covers the entry being written this cycle becoming the head.
        if (w_count_nxt == '0)                        w_head_nxt = 32'd0;
        else if (w_wr && (w_rd_ptr_nxt == r_wr_ptr))  w_head_nxt = w_wdata;
        else                                          w_head_nxt = r_mem[w_rd_ptr_nxt];
    end

    always_ff @(posedge clk) begin
        if (w_wr && !bus.clear) r_mem[r_wr_ptr] <= w_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_lap_time <= 32'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_count    <= w_count_nxt;
            r_lap_time <= w_head_nxt;
            if (w_lap_ok && w_full && !w_rd) r_overflow <= 1'b1;
        end
    end

    assign bus.xx           = r_xx;
    assign bus.ss           = r_ss;
    assign bus.mm           = r_mm;
    assign bus.hh           = r_hh;
    assign bus.running      = (r_state == S_RUN);
    assign bus.done         = r_done;
    assign bus.lap_time     = r_lap_time;
    assign bus.lap_count    = r_count;
    assign bus.lap_empty    = w_empty;
    assign bus.lap_full     = w_full;
    assign bus.lap_overflow = r_overflow;
endmodule

`default_nettype wire
